// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: received-byte strobe in, memory write port out
interface uart_boot_loader_if;
  logic [7:0]  uart_byte;
  logic        uart_byte_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  modport master (input uart_byte, uart_byte_ready, output mem_addr, mem_wdata, mem_we);
  modport slave  (output uart_byte, uart_byte_ready, input mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses 'L'/'G' byte frames into memory writes and CPU hold/reset control
module uart_boot_loader #(
  parameter int CLK_FRE       = 50,
  parameter int TIMEOUT_US    = 10000,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst,
  uart_boot_loader_if.master bus,
  output logic cpu_hold,
  output logic cpu_reset_req,
  output logic busy,
  output logic load_done,
  output logic err_chk,
  output logic err_timeout
);
  localparam int TO = CLK_FRE * TIMEOUT_US;
  localparam int TW = $clog2(TO + 1);
  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_G = 8'h47;
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, LEN, DATA, CHK} state_t;
  state_t state, state_nxt;
  logic [15:0] addr;
  logic [7:0]  sum, sum_nxt;
  logic [8:0]  cnt;
  logic [TW-1:0] tmo;
  logic expire, stb;
  assign busy    = state != IDLE;
  assign expire  = busy && tmo == TW'(TO - 1);
  assign stb     = bus.uart_byte_ready && !expire;
  assign sum_nxt = sum + bus.uart_byte;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state: timeout forces IDLE and discards a coincident strobe
  always_comb begin
    state_nxt = state;
    if (expire) state_nxt = IDLE;
    else if (stb)
      case (state)
        IDLE:    state_nxt = bus.uart_byte == CMD_L ? ADDR_H : IDLE;
        ADDR_H:  state_nxt = ADDR_L;
        ADDR_L:  state_nxt = LEN;
        LEN:     state_nxt = DATA;
        DATA:    state_nxt = cnt == 9'd1 ? CHK : DATA;
        default: state_nxt = IDLE;
      endcase
  end
  // inter-byte silence counter, only counts while a frame is open
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo <= '0;
    else tmo <= (!busy || bus.uart_byte_ready) ? '0 : tmo + 1'b1;
  // frame datapath, memory writes and status flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr          <= '0;
      sum           <= '0;
      cnt           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      cpu_hold      <= HOLD_AT_RESET;
      cpu_reset_req <= 1'b0;
      load_done     <= 1'b0;
      err_chk       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      bus.mem_we    <= 1'b0;
      cpu_reset_req <= 1'b0;
      load_done     <= 1'b0;
      if (expire) err_timeout <= 1'b1;
      else if (stb)
        case (state)
          IDLE:
            if (bus.uart_byte == CMD_L) begin
              cpu_hold    <= 1'b1;
              err_chk     <= 1'b0;
              err_timeout <= 1'b0;
              sum         <= '0;
            end else if (bus.uart_byte == CMD_G) begin
              cpu_hold      <= 1'b0;
              cpu_reset_req <= 1'b1;
            end
          ADDR_H: begin
            addr[15:8] <= bus.uart_byte;
            sum        <= sum_nxt;
          end
          ADDR_L: begin
            addr[7:0] <= bus.uart_byte;
            sum       <= sum_nxt;
          end
          LEN: begin
            cnt <= {bus.uart_byte == 8'h00, bus.uart_byte};
            sum <= sum_nxt;
          end
          DATA: begin
            sum           <= sum_nxt;
            bus.mem_addr  <= addr;
            bus.mem_wdata <= bus.uart_byte;
            bus.mem_we    <= 1'b1;
            addr          <= addr + 16'd1;
            cnt           <= cnt - 9'd1;
          end
          CHK:
            if (sum_nxt == 8'h00) load_done <= 1'b1;
            else err_chk <= 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames with a scoreboard checking every memory write
module tb_uart_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_hold, cpu_reset_req, busy, load_done, err_chk, err_timeout;
  uart_boot_loader_if bus();
  typedef struct {logic [15:0] a; logic [7:0] d; int c;} wr_t;
  wr_t sb[$];
  wr_t mon_e;
  logic [7:0] pay[$];
  int cyc = 0, errors = 0, checks = 0;
  int ld_cnt = 0, rr_cnt = 0, wcnt = 0;
  int l0, w0, r0;

  uart_boot_loader #(.CLK_FRE(1), .TIMEOUT_US(20), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cpu_hold(cpu_hold), .cpu_reset_req(cpu_reset_req), .busy(busy),
    .load_done(load_done), .err_chk(err_chk), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // monitor: pops an expected write whenever the DUT strobes mem_we
  always @(negedge clk) begin
    if (load_done) ld_cnt++;
    if (cpu_reset_req) rr_cnt++;
    if (bus.mem_we) begin
      wcnt++;
      chk("wr_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, mon_e.a);
        chk("wr_data", bus.mem_wdata, mon_e.d);
        chk("wr_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    bus.uart_byte = b;
    bus.uart_byte_ready = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.uart_byte_ready = 1'b0;
    end
  endtask

  task automatic put(input logic [7:0] b, input bit b2b);
    strobe(b);
    if (!b2b) gap(1);
  endtask

  task automatic send_l(input logic [15:0] a, input logic [7:0] len, input logic [7:0] c, input bit b2b);
    strobe(8'h4C);
    if (!b2b) begin
      gap(1);
      chk("l_clr_err_chk", err_chk, 0);
      chk("l_clr_err_to", err_timeout, 0);
      chk("l_busy", busy, 1);
      chk("l_hold", cpu_hold, 1);
    end
    put(a[15:8], b2b);
    put(a[7:0], b2b);
    put(len, b2b);
    foreach (pay[i]) begin
      strobe(pay[i]);
      sb.push_back('{a + 16'(i), pay[i], cyc + 1});
      if (!b2b) gap(1);
    end
    strobe(c);
    gap(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.uart_byte = 8'h00;
    bus.uart_byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_chk, err_timeout, load_done, cpu_reset_req}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    rst = 1'b0;
    gap(2);
    // good frame
    pay = '{8'hA9, 8'h01, 8'h00};
    l0 = ld_cnt;
    send_l(16'h0200, 8'h03, 8'h51, 1'b0);
    chk("f1_load_done", ld_cnt - l0, 1);
    chk("f1_err_chk", err_chk, 0);
    chk("f1_hold", cpu_hold, 1);
    chk("f1_busy", busy, 0);
    // bad checksum: writes still happen
    l0 = ld_cnt;
    send_l(16'h0200, 8'h03, 8'h52, 1'b0);
    chk("f2_load_done", ld_cnt - l0, 0);
    chk("f2_err_chk", err_chk, 1);
    chk("f2_hold", cpu_hold, 1);
    // address wrap; its 'L' clears err_chk
    pay = '{8'h11, 8'h22};
    l0 = ld_cnt;
    send_l(16'hFFFF, 8'h02, 8'hCD, 1'b0);
    chk("f3_load_done", ld_cnt - l0, 1);
    chk("f3_err_chk", err_chk, 0);
    // LEN = 0 means 256 bytes, sent back-to-back
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    l0 = ld_cnt;
    w0 = wcnt;
    send_l(16'h3000, 8'h00, 8'h50, 1'b1);
    chk("f4_writes", wcnt - w0, 256);
    chk("f4_load_done", ld_cnt - l0, 1);
    // timeout mid-header
    w0 = wcnt;
    put(8'h4C, 1'b0);
    put(8'h10, 1'b0);
    put(8'h00, 1'b0);
    gap(40);
    chk("to_err", err_timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_no_write", wcnt - w0, 0);
    // go command
    r0 = rr_cnt;
    put(8'h47, 1'b0);
    gap(3);
    chk("g_hold", cpu_hold, 0);
    chk("g_reset_pulse", rr_cnt - r0, 1);
    chk("g_err_to_sticky", err_timeout, 1);
    // back-to-back 4-byte frame
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    l0 = ld_cnt;
    send_l(16'h0400, 8'h04, 8'hC0, 1'b1);
    chk("f5_load_done", ld_cnt - l0, 1);
    chk("f5_hold", cpu_hold, 1);
    chk("f5_err_to", err_timeout, 0);
    // stray byte in IDLE
    w0 = wcnt;
    l0 = ld_cnt;
    r0 = rr_cnt;
    put(8'h00, 1'b0);
    gap(2);
    chk("stray_busy", busy, 0);
    chk("stray_hold", cpu_hold, 1);
    chk("stray_err", {err_chk, err_timeout}, 0);
    chk("stray_pulses", (wcnt - w0) + (ld_cnt - l0) + (rr_cnt - r0), 0);
    // reset during DATA
    put(8'h4C, 1'b0);
    put(8'h05, 1'b0);
    put(8'h00, 1'b0);
    put(8'h02, 1'b0);
    strobe(8'h77);
    sb.push_back('{16'h0500, 8'h77, cyc + 1});
    gap(1);
    strobe(8'h88);
    @(posedge clk);
    #1;
    chk("mr_we_pre", bus.mem_we, 1);
    bus.uart_byte_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_we", bus.mem_we, 0);
    chk("mr_busy", busy, 0);
    chk("mr_hold", cpu_hold, 1);
    chk("mr_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    gap(2);
    pay = '{8'hA9, 8'h01, 8'h00};
    l0 = ld_cnt;
    send_l(16'h0200, 8'h03, 8'h51, 1'b0);
    chk("mr_reload_done", ld_cnt - l0, 1);
    chk("mr_reload_err", err_chk, 0);
    gap(2);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Byte-stream controller that sits behind the UART receive path and sequences it. It parses framed load commands arriving as single-cycle byte strobes and issues write cycles into 6502 system memory. It holds the CPU while a load is in progress and releases it with a reset request on a go command. This lets host software download programs into the FPGA system over the serial link without re-synthesis.

Parameters:
CLK_FRE, 50, clock frequency in MHz; used only to size the timeout counter.
TIMEOUT_US, 10000, inter-byte timeout in microseconds while a frame is open; timeout count = CLK_FRE*TIMEOUT_US cycles.
HOLD_AT_RESET, 1, reset value of cpu_hold.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
uart_byte  input  8  received byte; valid only while uart_byte_ready is high.
uart_byte_ready  input  1  one-cycle strobe per received byte.
mem_addr  output  16  write address.
mem_wdata  output  8  write data.
mem_we  output  1  one-cycle write strobe. Memory accepts in the same cycle; no back-pressure.
cpu_hold  output  1  level; holds the 6502 (RDY low / bus released) while high.
cpu_reset_req  output  1  one-cycle pulse requesting a CPU reset.
busy  output  1  high whenever the FSM is not in IDLE.
load_done  output  1  one-cycle pulse when a frame's checksum verifies.
err_chk  output  1  sticky checksum error; cleared when the next 'L' is accepted.
err_timeout  output  1  sticky timeout error; cleared when the next 'L' is accepted.

Behaviour:
- Reset values: all outputs 0 except cpu_hold = HOLD_AT_RESET. FSM goes to IDLE; the address register and the running sum reset to 0.
- Frame 'L' (0x4C): sequence is ADDR_H, ADDR_L, LEN, then DATA x N, then CHK.
  - N = LEN, except LEN = 0 means N = 256.
  - CHK is chosen so that ADDR_H + ADDR_L + LEN + all DATA + CHK = 0 mod 256. The 'L' byte itself is excluded from the sum.
- Frame 'G' (0x47): no payload. Deasserts cpu_hold and pulses cpu_reset_req.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN, DATA, CHK. All transitions occur only on uart_byte_ready.
  - IDLE: 'L' -> ADDR_H. Also sets cpu_hold = 1, clears err_chk and err_timeout, and clears sum.
  - IDLE: 'G' -> stays in IDLE. cpu_hold <= 0 and cpu_reset_req = 1 in the next cycle.
  - IDLE: any other byte is ignored with no output change.
  - ADDR_H -> ADDR_L -> LEN: each step latches the byte and adds it to the sum.
  - LEN -> DATA; the remaining-byte count is loaded with N (9-bit).
  - DATA: each byte is added to the sum. mem_addr <= addr and mem_wdata <= byte, and mem_we is high for exactly the cycle after the strobe (latency 1). addr then increments, wrapping 0xFFFF -> 0x0000. After the Nth byte -> CHK.
  - CHK: if sum + byte == 0 mod 256, load_done pulses the next cycle; otherwise err_chk <= 1. Either way -> IDLE, and cpu_hold stays 1.
- Data already written before a bad checksum is not rolled back.
- 'L' and 'G' bytes that arrive inside an open frame are treated as payload, not as commands.
- Timeout: the counter resets on every strobe and runs only while the state is not IDLE. On reaching the timeout count: err_timeout <= 1, state -> IDLE, and no mem_we is issued.
- A strobe that arrives on the same cycle as the timeout expiry is discarded; the timeout wins.
- Strobes on consecutive cycles must be handled. One byte per cycle is sustained with no dropped bytes.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. Outputs return to their reset values and mem_we drops in the same cycle.
- mem_addr and mem_wdata hold their last values when mem_we is low.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- Send 'L',0x02,0x00,0x03,0xA9,0x01,0x00,CHK=0x51 -> three mem_we pulses, one cycle after each data strobe, at 0x0200/0x0201/0x0202 with data A9/01/00. load_done pulses once; err_chk = 0; cpu_hold = 1 throughout.
- Same frame with CHK = 0x52 -> the three writes still occur, err_chk = 1, and there is no load_done. A following 'L' clears err_chk.
- 'L',0xFF,0xFF,0x02,0x11,0x22,CHK -> writes go to 0xFFFF then 0x0000 (address wrap). LEN=0x00 with 256 data bytes -> exactly 256 mem_we pulses.
- 'L',0x10,0x00 followed by a silence longer than the timeout -> err_timeout = 1, busy = 0, no mem_we. A later 'G' -> cpu_hold falls and cpu_reset_req is high for exactly 1 cycle.
- Back-to-back strobes on every cycle for a 4-byte frame -> 4 consecutive mem_we cycles with correct data. A stray byte 0x00 in IDLE -> no output change.
- Assert rst during the DATA state -> mem_we = 0 and busy = 0 immediately, cpu_hold = HOLD_AT_RESET, and the next valid frame loads correctly.
